// File: rtl/spi_slv.sv
// SPI slave with host register interface, TX/RX byte FIFOs and all four SPI modes.
// SPI pins are oversampled in the clk_i domain through 2-flop synchronizers.
module spi_slv #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hs_read_i,
    input  logic       hs_write_i,
    input  logic [4:0] hs_addr_i,
    input  logic [7:0] hs_data_i,
    output logic       hs_ready_o,
    output logic [7:0] hs_data_o,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PUSH  = 2'd3
    } state_e;

    function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] i, input logic lsb);
        tx_bit = lsb ? b[i] : b[3'd7 - i];
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  sck_sync_q, cs_sync_q, mosi_sync_q, vld_q;
    logic        sck_prev_q, cs_prev_q, armed_q;
    logic [5:0]  ctrl_q, ctrl_d;
    logic [7:0]  dummy_q, dummy_d, cnt_q, cnt_d;
    logic        rx_ovr_q, rx_ovr_d, tx_und_q, tx_und_d;
    logic [7:0]  tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        miso_q, miso_d;
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [LW-1:0] tx_lvl_q, rx_lvl_q;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];

    logic       sck_s, cs_s, mosi_s, sck_rise_s, sck_fall_s, sample_s, shift_s, cs_fall_s;
    logic       tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [2:0] reg_sel_s;
    logic [7:0] status_s;
    logic       addr_unused_s;

    assign sck_s      = sck_sync_q[1];
    assign cs_s       = cs_sync_q[1];
    assign mosi_s     = mosi_sync_q[1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign sample_s   = (ctrl_q[3] == ctrl_q[4]) ? sck_rise_s : sck_fall_s;
    assign shift_s    = (ctrl_q[3] == ctrl_q[4]) ? sck_fall_s : sck_rise_s;
    // Only a fall seen after a genuine high level counts, so a reset inside a transfer waits for the next frame.
    assign cs_fall_s  = armed_q & cs_prev_q & ~cs_s;

    assign tx_empty_s = (tx_lvl_q == LW'(0));
    assign tx_full_s  = (tx_lvl_q == LW'(FIFO_DEPTH));
    assign rx_empty_s = (rx_lvl_q == LW'(0));
    assign rx_full_s  = (rx_lvl_q == LW'(FIFO_DEPTH));
    assign reg_sel_s  = hs_addr_i[4:2];
    assign tx_push_s  = hs_write_i & (reg_sel_s == 3'd2) & ~tx_full_s;
    assign tx_pop_s   = (state_q == ST_LOAD) & ~tx_empty_s;
    assign rx_push_s  = (state_q == ST_PUSH) & ~rx_full_s;
    assign rx_pop_s   = hs_read_i & (reg_sel_s == 3'd3) & ~rx_empty_s;
    assign status_s   = {1'b0, ~cs_s, tx_und_q, rx_ovr_q, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
    assign addr_unused_s = ^hs_addr_i[1:0];

    assign hs_ready_o = 1'b1;
    assign miso_o     = miso_q;
    assign miso_oe_o  = ~cs_sync_q[1];

    // Next-state logic for the transfer FSM, control registers and sticky flags.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = (hs_write_i && reg_sel_s == 3'd0) ? hs_data_i[5:0] : {ctrl_q[5:3], 3'b000};
        dummy_d   = (hs_write_i && reg_sel_s == 3'd6) ? hs_data_i : dummy_q;
        cnt_d     = cnt_q;
        rx_ovr_d  = ctrl_q[2] ? 1'b0 : rx_ovr_q;
        tx_und_d  = ctrl_q[2] ? 1'b0 : tx_und_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        miso_d    = miso_q;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                state_d   = cs_fall_s ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                if (tx_empty_s) begin
                    tx_sr_d  = dummy_q;
                    tx_und_d = 1'b1;
                end else begin
                    tx_sr_d  = tx_mem[tx_rp_q];
                end
                bit_cnt_d = 3'd0;
                miso_d    = tx_bit(tx_sr_d, 3'd0, ctrl_q[5]);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sample_s) begin
                    rx_sr_d   = ctrl_q[5] ? {mosi_s, rx_sr_q[7:1]} : {rx_sr_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = (bit_cnt_q == 3'd7) ? ST_PUSH : ST_SHIFT;
                end else if (shift_s) begin
                    // bit_cnt_q counts bits already sampled, so it indexes the bit to present next.
                    miso_d = tx_bit(tx_sr_q, bit_cnt_q, ctrl_q[5]);
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_PUSH: begin
                rx_ovr_d = rx_full_s ? 1'b1 : rx_ovr_d;
                cnt_d    = cnt_q + 8'd1;
                state_d  = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        state_d = cs_s ? ST_IDLE : state_d;
        miso_d  = (state_d == ST_IDLE) ? 1'b0 : miso_d;
    end

    // Synchronizers, FSM and control/status registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            vld_q       <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            ctrl_q      <= 6'd0;
            dummy_q     <= 8'hFF;
            cnt_q       <= 8'd0;
            rx_ovr_q    <= 1'b0;
            tx_und_q    <= 1'b0;
            tx_sr_q     <= 8'd0;
            rx_sr_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            miso_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            cs_sync_q   <= {cs_sync_q[0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            vld_q       <= {vld_q[0], 1'b1};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (vld_q[1] & cs_s);
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            dummy_q     <= dummy_d;
            cnt_q       <= cnt_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_und_q    <= tx_und_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
        end
    end

    // FIFO pointers and levels; a pending flush takes priority over push and pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_wp_q  <= AW'(0);
            tx_rp_q  <= AW'(0);
            tx_lvl_q <= LW'(0);
            rx_wp_q  <= AW'(0);
            rx_rp_q  <= AW'(0);
            rx_lvl_q <= LW'(0);
        end else begin
            if (ctrl_q[0]) begin
                tx_wp_q  <= AW'(0);
                tx_rp_q  <= AW'(0);
                tx_lvl_q <= LW'(0);
            end else begin
                tx_wp_q  <= tx_push_s ? tx_wp_q + AW'(1) : tx_wp_q;
                tx_rp_q  <= tx_pop_s ? tx_rp_q + AW'(1) : tx_rp_q;
                tx_lvl_q <= tx_lvl_q + LW'(tx_push_s) - LW'(tx_pop_s);
            end
            if (ctrl_q[1]) begin
                rx_wp_q  <= AW'(0);
                rx_rp_q  <= AW'(0);
                rx_lvl_q <= LW'(0);
            end else begin
                rx_wp_q  <= rx_push_s ? rx_wp_q + AW'(1) : rx_wp_q;
                rx_rp_q  <= rx_pop_s ? rx_rp_q + AW'(1) : rx_rp_q;
                rx_lvl_q <= rx_lvl_q + LW'(rx_push_s) - LW'(rx_pop_s);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        if (tx_push_s) begin
            tx_mem[tx_wp_q] <= hs_data_i;
        end
        if (rx_push_s) begin
            rx_mem[rx_wp_q] <= rx_sr_q;
        end
    end

    // Register read mux.
    always_comb begin
        hs_data_o = 8'd0;
        case (reg_sel_s)
            3'd0:    hs_data_o = {2'b00, ctrl_q};
            3'd1:    hs_data_o = status_s;
            3'd2:    hs_data_o = 8'd0;
            3'd3:    hs_data_o = rx_empty_s ? 8'd0 : rx_mem[rx_rp_q];
            3'd4:    hs_data_o = 8'(tx_lvl_q);
            3'd5:    hs_data_o = 8'(rx_lvl_q);
            3'd6:    hs_data_o = dummy_q;
            3'd7:    hs_data_o = cnt_q;
            default: hs_data_o = 8'd0;
        endcase
    end
endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: a bit-banged SPI master plus register accesses with hand-computed expectations.
module tb_spi_slv;
    localparam int HALF = 6;
    localparam logic [4:0] A_CTRL = 5'h00, A_STAT = 5'h04, A_TXD = 5'h08, A_RXD = 5'h0C;
    localparam logic [4:0] A_TXL = 5'h10, A_RXL = 5'h14, A_DUM = 5'h18, A_CNT = 5'h1C;

    logic       clk_i = 1'b0;
    logic       rst_ni, hs_read_i, hs_write_i, hs_ready_o;
    logic [4:0] hs_addr_i;
    logic [7:0] hs_data_i, hs_data_o;
    logic       sck_i, cs_ni, mosi_i, miso_o, miso_oe_o;
    int         n_checks = 0;
    int         n_errors = 0;
    logic       cpha = 1'b0;
    logic       lsb = 1'b0;
    logic [7:0] r0, r1;

    spi_slv #(.FIFO_DEPTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .hs_read_i(hs_read_i), .hs_write_i(hs_write_i),
        .hs_addr_i(hs_addr_i), .hs_data_i(hs_data_i), .hs_ready_o(hs_ready_o), .hs_data_o(hs_data_o),
        .sck_i(sck_i), .cs_ni(cs_ni), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic reg_wr(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        hs_write_i = 1'b1; hs_addr_i = addr; hs_data_i = data;
        @(negedge clk_i);
        hs_write_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [4:0] addr, output logic [7:0] data);
        @(negedge clk_i);
        hs_read_i = 1'b1; hs_addr_i = addr;
        #1 data = hs_data_o;
        @(negedge clk_i);
        hs_read_i = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        reg_rd(addr, d);
        check_val(tag, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic l);
        reg_wr(A_CTRL, {2'b00, l, pha, pol, 3'b000});
        cpha = pha; lsb = l; sck_i = pol;
        wait_clk(4);
    endtask

    task automatic cs_start();
        @(negedge clk_i);
        cs_ni = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_stop();
        wait_clk(HALF);
        cs_ni = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : 7 - i;
            if (!cpha) begin
                mosi_i = tx[idx];
                wait_clk(HALF);
                rx[idx] = miso_o;
                sck_i = ~sck_i;
                wait_clk(HALF);
                sck_i = ~sck_i;
            end else begin
                sck_i = ~sck_i;
                mosi_i = tx[idx];
                wait_clk(HALF);
                rx[idx] = miso_o;
                sck_i = ~sck_i;
                wait_clk(HALF);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0; hs_read_i = 1'b0; hs_write_i = 1'b0; hs_addr_i = 5'd0; hs_data_i = 8'd0;
        sck_i = 1'b0; cs_ni = 1'b1; mosi_i = 1'b0;
        wait_clk(3);
        check_val("rst_ready", {31'd0, hs_ready_o}, 32'd1);
        check_val("rst_miso", {31'd0, miso_o}, 32'd0);
        check_val("rst_oe", {31'd0, miso_oe_o}, 32'd0);
        rst_ni = 1'b1;
        wait_clk(4);
        chk_reg("rst_status", A_STAT, 8'h05);
        chk_reg("rst_ctrl", A_CTRL, 8'h00);
        chk_reg("rst_dummy", A_DUM, 8'hFF);
        chk_reg("rst_cnt", A_CNT, 8'h00);
        chk_reg("rst_txlvl", A_TXL, 8'h00);
        chk_reg("rst_rxlvl", A_RXL, 8'h00);

        // Mode 0, MSB first, single byte
        reg_wr(A_TXD, 8'hA5);
        chk_reg("m0_txlvl1", A_TXL, 8'h01);
        chk_reg("txd_reads0", A_TXD, 8'h00);
        cs_start();
        check_val("m0_oe", {31'd0, miso_oe_o}, 32'd1);
        check_val("m0_firstbit", {31'd0, miso_o}, 32'd1);
        chk_reg("m0_status_act", A_STAT, 8'h45);
        spi_bits(8'h3C, 8, r0);
        cs_stop();
        check_val("m0_miso", {24'd0, r0}, 32'hA5);
        chk_reg("m0_status", A_STAT, 8'h24);
        chk_reg("m0_rxlvl", A_RXL, 8'h01);
        chk_reg("m0_txlvl0", A_TXL, 8'h00);
        chk_reg("m0_cnt", A_CNT, 8'h01);
        chk_reg("m0_rxd", A_RXD, 8'h3C);
        chk_reg("m0_rxlvl0", A_RXL, 8'h00);

        // Modes 1..3, LSB first, two-byte bursts
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            reg_wr(A_TXD, 8'h12);
            reg_wr(A_TXD, 8'h34);
            cs_start();
            spi_bits(8'h81, 8, r0);
            spi_bits(8'h7E, 8, r1);
            cs_stop();
            check_val($sformatf("m%0d_miso0", m), {24'd0, r0}, 32'h12);
            check_val($sformatf("m%0d_miso1", m), {24'd0, r1}, 32'h34);
            chk_reg($sformatf("m%0d_rxd0", m), A_RXD, 8'h81);
            chk_reg($sformatf("m%0d_rxd1", m), A_RXD, 8'h7E);
            chk_reg($sformatf("m%0d_cnt", m), A_CNT, 8'(1 + 2 * m));
        end

        // Underrun with dummy byte, then sticky clear
        set_mode(1'b0, 1'b0, 1'b0);
        reg_wr(A_CTRL, 8'h04);
        wait_clk(2);
        chk_reg("ur_pre_status", A_STAT, 8'h05);
        reg_wr(A_DUM, 8'h5A);
        chk_reg("ur_dummy", A_DUM, 8'h5A);
        cs_start();
        spi_bits(8'hC3, 8, r0);
        cs_stop();
        check_val("ur_miso", {24'd0, r0}, 32'h5A);
        chk_reg("ur_status", A_STAT, 8'h24);
        chk_reg("ur_rxd", A_RXD, 8'hC3);
        reg_wr(A_CTRL, 8'h04);
        wait_clk(2);
        chk_reg("ur_cleared", A_STAT, 8'h05);
        chk_reg("ur_ctrl_selfclr", A_CTRL, 8'h00);
        chk_reg("ur_cnt", A_CNT, 8'h08);

        // CS rises after 5 bits
        reg_wr(A_TXD, 8'hE7);
        cs_start();
        spi_bits(8'h55, 5, r0);
        cs_stop();
        check_val("part_miso", {24'd0, r0}, 32'hE0);
        chk_reg("part_status", A_STAT, 8'h05);
        chk_reg("part_rxlvl", A_RXL, 8'h00);
        chk_reg("part_txlvl", A_TXL, 8'h00);
        chk_reg("part_cnt", A_CNT, 8'h08);
        reg_wr(A_TXD, 8'h96);
        cs_start();
        spi_bits(8'h5B, 8, r0);
        cs_stop();
        check_val("part_next_miso", {24'd0, r0}, 32'h96);
        chk_reg("part_next_rxd", A_RXD, 8'h5B);
        chk_reg("part_next_cnt", A_CNT, 8'h09);
        reg_wr(A_CTRL, 8'h04);

        // RX overrun: FIFO_DEPTH+1 bytes without reads
        cs_start();
        for (int i = 0; i < 17; i++) spi_bits(8'(8'h40 + i), 8, r0);
        cs_stop();
        chk_reg("ovr_rxlvl", A_RXL, 8'h10);
        chk_reg("ovr_status", A_STAT, 8'h36);
        chk_reg("ovr_cnt", A_CNT, 8'h1A);
        for (int i = 0; i < 16; i++) chk_reg($sformatf("ovr_rxd%0d", i), A_RXD, 8'(8'h40 + i));
        chk_reg("ovr_rxlvl0", A_RXL, 8'h00);

        // TX full, then flush
        for (int i = 0; i < 17; i++) reg_wr(A_TXD, 8'(i));
        chk_reg("txfull_lvl", A_TXL, 8'h10);
        chk_reg("txfull_status", A_STAT, 8'h39);
        reg_wr(A_CTRL, 8'h05);
        wait_clk(2);
        chk_reg("flush_txlvl", A_TXL, 8'h00);

        // Reset mid-byte with data in both FIFOs
        reg_wr(A_TXD, 8'h11);
        reg_wr(A_TXD, 8'h22);
        reg_wr(A_TXD, 8'h33);
        reg_wr(A_DUM, 8'h77);
        cs_start();
        spi_bits(8'hA0, 8, r0);
        check_val("rm_miso", {24'd0, r0}, 32'h11);
        spi_bits(8'hFF, 4, r1);
        chk_reg("rm_pre_txlvl", A_TXL, 8'h01);
        chk_reg("rm_pre_rxlvl", A_RXL, 8'h01);
        @(negedge clk_i);
        rst_ni = 1'b0;
        wait_clk(2);
        check_val("rm_oe", {31'd0, miso_oe_o}, 32'd0);
        check_val("rm_miso_rst", {31'd0, miso_o}, 32'd0);
        check_val("rm_ready", {31'd0, hs_ready_o}, 32'd1);
        rst_ni = 1'b1;
        wait_clk(2);
        chk_reg("rm_txlvl", A_TXL, 8'h00);
        chk_reg("rm_rxlvl", A_RXL, 8'h00);
        chk_reg("rm_ctrl", A_CTRL, 8'h00);
        chk_reg("rm_dummy", A_DUM, 8'hFF);
        chk_reg("rm_cnt", A_CNT, 8'h00);
        spi_bits(8'hFF, 4, r1);
        cs_stop();
        chk_reg("rm_status", A_STAT, 8'h05);
        check_val("rm_oe_idle", {31'd0, miso_oe_o}, 32'd0);
        cs_start();
        spi_bits(8'h69, 8, r0);
        cs_stop();
        check_val("rs_miso", {24'd0, r0}, 32'hFF);
        chk_reg("rs_rxd", A_RXD, 8'h69);
        chk_reg("rs_cnt", A_CNT, 8'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_slv.md
SPI_SLV -- requirements
Module: spi_slv

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, depth in bytes of each of the TX and RX FIFOs; power of two, at most 128.
REQ-002 clk_i  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset; synchronous, active-low.
REQ-004 hs_read_i  input  1  register read strobe, one cycle.
REQ-005 hs_write_i  input  1  register write strobe, one cycle.
REQ-006 hs_addr_i  input  5  byte address; hs_addr_i[4:2] selects register 0-7.
REQ-007 hs_data_i  input  8  write data.
REQ-008 hs_ready_o  output  1  tied 1; zero-latency access.
REQ-009 hs_data_o  output  8  read data; combinational from the selected register.
REQ-010 sck_i  input  1  SPI clock from the master; asynchronous to clk_i.
REQ-011 cs_ni  input  1  chip select from the master, active-low, asynchronous.
REQ-012 mosi_i  input  1  master-out data, asynchronous.
REQ-013 miso_o  output  1  slave-out data.
REQ-014 miso_oe_o  output  1  MISO output enable; 1 only while synchronized CS is low.

Function
REQ-015 Register map: 0x00 ctrl RW; 0x04 status RO; 0x08 TX data WO, reads 0; 0x0C RX data RO (head of the RX FIFO); 0x10 TX level RO; 0x14 RX level RO; 0x18 dummy byte RW; 0x1C bytes-received counter RO.
REQ-016 Ctrl bits: [0] TX FIFO flush, [1] RX FIFO flush, [2] clear sticky flags (all three self-clearing one cycle after being set); [3] CPOL; [4] CPHA; [5] LSB-first; [7:6] reserved, read 0.
REQ-017 Status bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overrun (sticky), [5] tx_underrun (sticky), [6] cs_active, [7] 0.
REQ-018 A write to 0x08 pushes hs_data_i into the TX FIFO; it is ignored while the FIFO is full.
REQ-019 A read of 0x0C pops the RX FIFO; it is ignored while the FIFO is empty.
REQ-020 sck_i, cs_ni and mosi_i each pass through a 2-flop synchronizer; SCK edges are detected on the synchronized signal.
REQ-021 Supported SCK rate: the SCK high and low phases are each at least 4 clk_i cycles.
REQ-022 The sample edge is the SCK rising edge when CPOL==CPHA and the falling edge otherwise; the shift edge is the opposite edge.
REQ-023 FSM states: IDLE, LOAD, SHIFT, PUSH.
REQ-024 IDLE -> LOAD on a synchronized CS falling edge.
REQ-025 In LOAD (one cycle) the TX FIFO is popped into the shift register; if the FIFO is empty, the dummy byte is loaded instead and tx_underrun is set.
REQ-026 LOAD -> SHIFT after one cycle; the first bit is on miso_o from the end of LOAD.
REQ-027 In SHIFT, each sample edge shifts in mosi and increments a 3-bit bit counter.
REQ-028 In SHIFT, each shift edge presents the next TX bit; with CPHA=1 the first shift edge presents bit 0 of the byte.
REQ-029 SHIFT -> PUSH on the 8th sample edge.
REQ-030 PUSH (one cycle) writes the received byte into the RX FIFO and increments the bytes-received counter, which wraps 255 -> 0.
REQ-031 PUSH -> LOAD when CS is still low; PUSH -> IDLE when CS is high.
REQ-032 If the RX FIFO is full at PUSH, the byte is dropped, rx_overrun is set and the counter still increments.
REQ-033 A CS rise in any state forces IDLE on the next cycle: a partial byte is discarded and not pushed; a TX byte already popped is not restored.
REQ-034 Bit order: MSB first when ctrl[5]=0, LSB first when ctrl[5]=1, applied to both TX and RX.
REQ-035 miso_o is 0 in IDLE.
REQ-036 Simultaneous TX push and pop leaves the TX level unchanged; the same holds for the RX FIFO.
REQ-037 Writing ctrl[2] together with a flag-setting event leaves the flag set.
REQ-038 A FIFO flush zeroes that FIFO's level on the next cycle; a flush during a transfer does not abort the transfer.

Reset
REQ-039 With rst_ni=0 at a rising clk_i edge, the block goes to IDLE, both FIFOs are empty, ctrl=0, dummy=0xFF, the counter is 0 and the flags are 0.
REQ-040 Output values under reset: miso_o=0, miso_oe_o=0, hs_ready_o=1.
REQ-041 A reset asserted mid-transfer abandons the byte; the slave resynchronizes on the next CS falling edge.

Verification
REQ-042 Mode 0, MSB first; TX FIFO holds 0xA5; master sends 0x3C -> master receives 0xA5; RX FIFO holds 0x3C; TX level 0; counter 1.
REQ-043 Modes 1, 2 and 3, LSB first; two-byte burst 0x81,0x7E with TX 0x12,0x34 -> RX reads 0x81 then 0x7E; master receives 0x12,0x34.
REQ-044 TX FIFO empty, dummy=0x5A, one byte -> master receives 0x5A; tx_underrun=1; the flag clears after a ctrl[2] write.
REQ-045 FIFO_DEPTH+1 bytes sent without reads -> RX level FIFO_DEPTH; rx_overrun=1; the first FIFO_DEPTH bytes are intact.
REQ-046 CS rises after 5 bits -> no RX push; the state returns to IDLE; the next full byte is received correctly.
REQ-047 Reset asserted mid-byte with data in both FIFOs -> all levels 0, registers at their reset values, miso_oe_o=0.
